// File: rtl/arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds FSM encoding, requester IDs and the latency counter width helper.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic REQ_C = 1'b0;
    localparam logic REQ_D = 1'b1;

    // Bits needed to hold MEM_LAT-1 (never less than one bit).
    function automatic int lat_cnt_w(input int lat);
        int w;
        w = 1;
        for (int i = 1; i < 5; i++) begin
            if ((1 << i) < lat) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between core and DMA requests.
// Round-robin tie-break when ARB_RR_EN is defined, else fixed core priority.
module arb_pick
    import arb_pkg::*;
(
`ifdef ARB_RR_EN
    input  logic rr_last,
`endif
    input  logic core_req,
    input  logic dma_req,
    output logic valid,
    output logic winner
);

    // Pick a winner from the current request pair.
    always_comb begin
        valid  = core_req | dma_req;
        winner = REQ_C;
`ifdef ARB_RR_EN
        if (core_req && dma_req) begin
            winner = ~rr_last;
        end else if (dma_req) begin
            winner = REQ_D;
        end
`else
        if (!core_req && dma_req) begin
            winner = REQ_D;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between the core and a DMA engine.
// Optional round-robin arbitration via ARB_RR_EN (default: core priority).
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    output logic              core_stall_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic              dma_gnt_o,
    output logic              dma_rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CNT_W = lat_cnt_w(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             owner;
    logic             pick_valid;
    logic             pick_winner;
    logic             accept;
    logic             sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef ARB_RR_EN
    logic rr_last;
`endif

    arb_pick u_pick (
`ifdef ARB_RR_EN
        .rr_last  (rr_last),
`endif
        .core_req (core_req_i),
        .dma_req  (dma_req_i),
        .valid    (pick_valid),
        .winner   (pick_winner)
    );

    // Grants are only issued from IDLE and are suppressed while in reset.
    assign accept       = (state == IDLE) & pick_valid & ~rst;
    assign core_gnt_o   = accept & (pick_winner == REQ_C);
    assign dma_gnt_o    = accept & (pick_winner == REQ_D);
    assign core_stall_o = core_req_i & ~core_rvalid_o;

    // Mux the winning requester's command for latching.
    always_comb begin
        sel_we    = core_we_i;
        sel_addr  = core_addr_i;
        sel_wdata = core_wdata_i;
        if (pick_winner == REQ_D) begin
            sel_we    = dma_we_i;
            sel_addr  = dma_addr_i;
            sel_wdata = dma_wdata_i;
        end
    end

    // Access FSM: accept, hold command for MEM_LAT cycles, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            owner         <= REQ_C;
            mem_read_o    <= 1'b0;
            mem_write_o   <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            rdata_o       <= '0;
            core_rvalid_o <= 1'b0;
            dma_rvalid_o  <= 1'b0;
        end else begin
            core_rvalid_o <= 1'b0;
            dma_rvalid_o  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        owner       <= pick_winner;
                        cnt         <= CNT_INIT;
                        mem_read_o  <= ~sel_we;
                        mem_write_o <= sel_we;
                        mem_addr_o  <= sel_addr;
                        mem_wdata_o <= sel_wdata;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        if (mem_read_o) begin
                            rdata_o <= mem_rdata_i;
                        end
                        mem_read_o    <= 1'b0;
                        mem_write_o   <= 1'b0;
                        core_rvalid_o <= (owner == REQ_C);
                        dma_rvalid_o  <= (owner == REQ_D);
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_RR_EN
    // Remember the last granted port for the round-robin tie-break.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last <= REQ_D;
        end else if (accept) begin
            rr_last <= pick_winner;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2.
// Inputs change 2ns after posedge; outputs are sampled 1ns later.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req_i, core_we_i;
    logic [AW-1:0] core_addr_i;
    logic [DW-1:0] core_wdata_i;
    logic          core_gnt_o, core_rvalid_o, core_stall_o;
    logic          dma_req_i, dma_we_i;
    logic [AW-1:0] dma_addr_i;
    logic [DW-1:0] dma_wdata_i;
    logic          dma_gnt_o, dma_rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          mem_read_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    assign mem_rdata_i = (mem_addr_o == 32'h40) ? 32'hDEAD_BEEF
                                                : (mem_addr_o ^ 32'hA5A5_0000);

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_addr_i  (core_addr_i),
        .core_wdata_i (core_wdata_i),
        .core_gnt_o   (core_gnt_o),
        .core_rvalid_o(core_rvalid_o),
        .core_stall_o (core_stall_o),
        .dma_req_i    (dma_req_i),
        .dma_we_i     (dma_we_i),
        .dma_addr_i   (dma_addr_i),
        .dma_wdata_i  (dma_wdata_i),
        .dma_gnt_o    (dma_gnt_o),
        .dma_rvalid_o (dma_rvalid_o),
        .rdata_o      (rdata_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        core_req_i = 1'b0; core_we_i = 1'b0;
        core_addr_i = '0; core_wdata_i = '0;
        dma_req_i = 1'b0; dma_we_i = 1'b0;
        dma_addr_i = '0; dma_wdata_i = '0;
        tick(); tick();
        #1;
        vecs++;
        if ({core_gnt_o, dma_gnt_o, core_rvalid_o, dma_rvalid_o,
             mem_read_o, mem_write_o, core_stall_o} !== 7'b0) begin
            errs++;
            $display("FAIL reset_ctrl: got %b want 0", {core_gnt_o, dma_gnt_o,
                     core_rvalid_o, dma_rvalid_o, mem_read_o, mem_write_o, core_stall_o});
        end
        vecs++;
        if ({mem_addr_o, mem_wdata_o, rdata_o} !== 96'h0) begin
            errs++;
            $display("FAIL reset_data: got %h %h %h want 0", mem_addr_o, mem_wdata_o, rdata_o);
        end
        core_req_i = 1'b1;
        #1;
        vecs++;
        if ({core_gnt_o, core_stall_o} !== 2'b01) begin
            errs++;
            $display("FAIL reset_req: gnt/stall got %b want 01", {core_gnt_o, core_stall_o});
        end
        core_req_i = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_core_read();
        tick();
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h40;
        #1;
        vecs++;
        if ({core_gnt_o, dma_gnt_o, core_stall_o} !== 3'b101) begin
            errs++;
            $display("FAIL cr_gnt: got %b want 101", {core_gnt_o, dma_gnt_o, core_stall_o});
        end
        tick();
        core_addr_i = 32'h44;
        #1;
        vecs++;
        if ({mem_read_o, mem_write_o, core_gnt_o, core_stall_o, core_rvalid_o} !== 5'b10010
            || mem_addr_o !== 32'h40) begin
            errs++;
            $display("FAIL cr_busy1: got %b addr %h want 10010 addr 40",
                     {mem_read_o, mem_write_o, core_gnt_o, core_stall_o, core_rvalid_o}, mem_addr_o);
        end
        tick();
        #1;
        vecs++;
        if ({mem_read_o, core_gnt_o, core_stall_o, core_rvalid_o} !== 4'b1010
            || mem_addr_o !== 32'h40) begin
            errs++;
            $display("FAIL cr_busy2: got %b addr %h want 1010 addr 40",
                     {mem_read_o, core_gnt_o, core_stall_o, core_rvalid_o}, mem_addr_o);
        end
        tick();
        #1;
        vecs++;
        if ({core_rvalid_o, dma_rvalid_o, core_stall_o, mem_read_o} !== 4'b1000
            || rdata_o !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL cr_resp: got %b rdata %h want 1000 rdata deadbeef",
                     {core_rvalid_o, dma_rvalid_o, core_stall_o, mem_read_o}, rdata_o);
        end
        core_req_i = 1'b0;
        tick();
        #1;
        vecs++;
        if ({core_rvalid_o, core_gnt_o} !== 2'b00) begin
            errs++;
            $display("FAIL cr_idle: got %b want 00", {core_rvalid_o, core_gnt_o});
        end
    endtask

    task automatic test_dma_write();
        dma_req_i = 1'b1; dma_we_i = 1'b1;
        dma_addr_i = 32'h80; dma_wdata_i = 32'h1234_5678;
        #1;
        vecs++;
        if ({dma_gnt_o, core_gnt_o, core_stall_o} !== 3'b100) begin
            errs++;
            $display("FAIL dw_gnt: got %b want 100", {dma_gnt_o, core_gnt_o, core_stall_o});
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            dma_req_i = 1'b0;
            dma_wdata_i = 32'hFFFF_FFFF;
            #1;
            vecs++;
            if ({mem_write_o, mem_read_o, dma_rvalid_o} !== 3'b100
                || mem_wdata_o !== 32'h1234_5678 || mem_addr_o !== 32'h80) begin
                errs++;
                $display("FAIL dw_busy%0d: got %b wdata %h addr %h want 100 12345678 80",
                         i, {mem_write_o, mem_read_o, dma_rvalid_o}, mem_wdata_o, mem_addr_o);
            end
        end
        tick();
        #1;
        vecs++;
        if ({dma_rvalid_o, core_rvalid_o, mem_write_o} !== 3'b100
            || rdata_o !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL dw_resp: got %b rdata %h want 100 rdata deadbeef",
                     {dma_rvalid_o, core_rvalid_o, mem_write_o}, rdata_o);
        end
    endtask

    task automatic test_simultaneous();
        logic exp_c, exp_d;
        tick();
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h100;
        dma_req_i = 1'b1; dma_we_i = 1'b0; dma_addr_i = 32'h200;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            #1;
            exp_c = (k % 4 == 0) && !(RR && ((k / 4) % 2 == 1));
            exp_d = (k % 4 == 0) && RR && ((k / 4) % 2 == 1);
            vecs++;
            if ({core_gnt_o, dma_gnt_o} !== {exp_c, exp_d}) begin
                errs++;
                $display("FAIL sim_gnt k=%0d: got %b want %b", k,
                         {core_gnt_o, dma_gnt_o}, {exp_c, exp_d});
            end
            vecs++;
            if ((core_rvalid_o & dma_rvalid_o) !== 1'b0) begin
                errs++;
                $display("FAIL sim_rvalid k=%0d: got both want exclusive", k);
            end
        end
        core_req_i = 1'b0;
        dma_req_i = 1'b0;
    endtask

    task automatic test_core_during_dma();
        tick();
        dma_req_i = 1'b1; dma_we_i = 1'b0; dma_addr_i = 32'h300;
        #1;
        vecs++;
        if (dma_gnt_o !== 1'b1) begin
            errs++;
            $display("FAIL cd_dgnt: got %b want 1", dma_gnt_o);
        end
        tick();
        dma_req_i = 1'b0;
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h40;
        #1;
        vecs++;
        if ({core_stall_o, core_gnt_o} !== 2'b10) begin
            errs++;
            $display("FAIL cd_stall1: got %b want 10", {core_stall_o, core_gnt_o});
        end
        tick();
        #1;
        vecs++;
        if ({core_stall_o, core_gnt_o} !== 2'b10) begin
            errs++;
            $display("FAIL cd_stall2: got %b want 10", {core_stall_o, core_gnt_o});
        end
        tick();
        #1;
        vecs++;
        if ({dma_rvalid_o, core_rvalid_o, core_stall_o, core_gnt_o} !== 4'b1010
            || rdata_o !== 32'hA5A5_0300) begin
            errs++;
            $display("FAIL cd_dresp: got %b rdata %h want 1010 a5a50300",
                     {dma_rvalid_o, core_rvalid_o, core_stall_o, core_gnt_o}, rdata_o);
        end
        tick();
        #1;
        vecs++;
        if ({core_gnt_o, dma_gnt_o, core_stall_o} !== 3'b101) begin
            errs++;
            $display("FAIL cd_cgnt: got %b want 101", {core_gnt_o, dma_gnt_o, core_stall_o});
        end
        tick(); tick(); tick();
        #1;
        vecs++;
        if ({core_rvalid_o, core_stall_o} !== 2'b10 || rdata_o !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL cd_cresp: got %b rdata %h want 10 deadbeef",
                     {core_rvalid_o, core_stall_o}, rdata_o);
        end
        core_req_i = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        tick();
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h40;
        #1;
        vecs++;
        if (core_gnt_o !== 1'b1) begin
            errs++;
            $display("FAIL rb_gnt: got %b want 1", core_gnt_o);
        end
        tick();
        #1;
        vecs++;
        if (mem_read_o !== 1'b1) begin
            errs++;
            $display("FAIL rb_busy: mem_read got %b want 1", mem_read_o);
        end
        rst = 1'b1;
        #1;
        vecs++;
        if ({mem_read_o, mem_write_o, core_gnt_o, core_rvalid_o, core_stall_o} !== 5'b00001
            || mem_addr_o !== 32'h0 || rdata_o !== 32'h0) begin
            errs++;
            $display("FAIL rb_async: got %b addr %h rdata %h want 00001 0 0",
                     {mem_read_o, mem_write_o, core_gnt_o, core_rvalid_o, core_stall_o},
                     mem_addr_o, rdata_o);
        end
        tick();
        #1;
        vecs++;
        if ({core_rvalid_o, dma_rvalid_o, core_gnt_o} !== 3'b000) begin
            errs++;
            $display("FAIL rb_hold: got %b want 000", {core_rvalid_o, dma_rvalid_o, core_gnt_o});
        end
        tick();
        rst = 1'b0;
        #1;
        vecs++;
        if (core_gnt_o !== 1'b1) begin
            errs++;
            $display("FAIL rb_regnt: got %b want 1", core_gnt_o);
        end
        tick(); tick(); tick();
        #1;
        vecs++;
        if (core_rvalid_o !== 1'b1 || rdata_o !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL rb_resp: rvalid %b rdata %h want 1 deadbeef", core_rvalid_o, rdata_o);
        end
        core_req_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_dma_write();
        test_simultaneous();
        test_core_during_dma();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
